// File: rtl/rom_reader_pkg.sv
// Shared types and helpers for the ROM burst reader: FSM states, latency tags,
// and output FIFO sizing.
package rom_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  // One slot per in-flight ROM read plus one, so issue can continue while the head is popped.
  function automatic int fifo_depth(input int rom_latency);
    return rom_latency + 1;
  endfunction

endpackage

// File: rtl/rom_burst_reader_if.sv
// Request, ROM and output-stream signals of the burst reader; the engine
// takes the slave side, its surroundings the master side.
interface rom_burst_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  rom_rd;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;

  modport slave (
    input  req_valid, req_addr, req_len, rom_data, out_ready,
    output req_ready, rom_rd, rom_addr, out_valid, out_data, out_last, busy
  );

  modport master (
    output req_valid, req_addr, req_len, rom_data, out_ready,
    input  req_ready, rom_rd, rom_addr, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/rom_reader_fifo.sv
// First-word-fall-through FIFO with an empty-bypass path, so a word pushed
// into an empty FIFO is visible at the output in the same cycle.
module rom_reader_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             din_i,
  input  logic                         pop_i,
  output logic                         valid_o,
  output logic [WIDTH-1:0]             dout_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    count_q;
  logic             empty, bypass, wr_en, rd_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  // Push and pop on an empty FIFO hand the word straight through without storing it.
  assign bypass  = empty && push_i && pop_i;
  assign wr_en   = push_i && !bypass;
  assign rd_en   = pop_i && !empty;
  assign valid_o = !empty || push_i;
  assign dout_o  = (empty && push_i) ? din_i : mem_q[rd_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (rd_en) rd_q <= ptr_inc(rd_q);
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/rom_burst_reader.sv
// Burst read engine: takes (addr, len) requests, issues pipelined reads to a
// fixed-latency synchronous ROM and streams words out with backpressure.
module rom_burst_reader
  import rom_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int LEN_WIDTH   = 8,
  parameter int ROM_LATENCY = 2
) (
  input logic                clock,
  input logic                reset,
  rom_burst_reader_if.slave  bus
);
  localparam int FIFO_DEPTH = fifo_depth(ROM_LATENCY);
  localparam int CW         = $clog2(ROM_LATENCY + 2);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  rom_rd_q, rom_rd_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  last_q, last_d;
  tag_t                  tags_q [ROM_LATENCY];
  logic [CW-1:0]         in_flight_q, in_flight_d;
  logic [CW-1:0]         fifo_count;
  logic                  push, pop, fifo_valid, credit_ok;
  logic [DATA_WIDTH:0]   fifo_dout;
  logic [CW:0]           occupancy;

  assign push = tags_q[ROM_LATENCY-1].valid;
  assign pop  = fifo_valid && bus.out_ready;

  // Every word issued but not yet consumed must have a FIFO slot waiting for it.
  assign occupancy = {1'b0, in_flight_q} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
  assign credit_ok = occupancy < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    rom_rd_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    last_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          cur_addr_d  = bus.req_addr;
          remaining_d = bus.req_len;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          rom_rd_d   = 1'b1;
          rom_addr_d = cur_addr_q;
          cur_addr_d = cur_addr_q + 1'b1;
          if (remaining_q == '0) begin
            last_d  = 1'b1;
            state_d = DRAIN;
          end else begin
            remaining_d = remaining_q - 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pop && fifo_dout[DATA_WIDTH]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_flight_d = in_flight_q + CW'(rom_rd_d) - CW'(push);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      rom_rd_q    <= 1'b0;
      rom_addr_q  <= '0;
      last_q      <= 1'b0;
      in_flight_q <= '0;
      for (int unsigned i = 0; i < ROM_LATENCY; i++) tags_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      rom_rd_q    <= rom_rd_d;
      rom_addr_q  <= rom_addr_d;
      last_q      <= last_d;
      in_flight_q <= in_flight_d;
      // The tag leaves the last stage in the same cycle the ROM presents its data.
      tags_q[0]   <= '{valid: rom_rd_q, last: last_q};
      for (int unsigned i = 1; i < ROM_LATENCY; i++) tags_q[i] <= tags_q[i-1];
    end
  end

  rom_reader_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (push),
    .din_i   ({tags_q[ROM_LATENCY-1].last, bus.rom_data}),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .dout_o  (fifo_dout),
    .count_o (fifo_count)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rom_rd    = rom_rd_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = fifo_dout[DATA_WIDTH-1:0];
  assign bus.out_last  = fifo_dout[DATA_WIDTH];

endmodule
